// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec
//
// Execute stage fed by the ALU control decoder. It conditions two 16-bit
// operands, computes an adder/logic or shifter result plus Z/N/C/V flags, and
// registers the bundle into an execute-to-memory stage. That stage has a
// valid/ready handshake, a 2-entry (main + skid) buffer and a synchronous
// flush.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous flush of both buffer entries
//   in_valid / in_ready   input handshake (in_ready is a registered signal)
//   a, b                  16-bit operands
//   alu_op                operation select (rol/sll/sra/srl/add/or/xor/and)
//   inv_a, inv_b, cin     operand inversion and adder carry-in
//   shamt                 shift/rotate amount
//   flip_1, flip_2        bit-reverse the shifter input / output
//   shift                 1 = shifter path, 0 = adder/logic path
//   SLBI                  OR b[7:0] into the shifter result
//   tag_in / tag_out      pass-through destination tag
//   out_valid / out_ready output handshake
//   result, flag_*        registered result and condition flags
// ---------------------------------------------------------------------------
module alu_exec #(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [2:0]       alu_op,
  input  logic             inv_a,
  input  logic             inv_b,
  input  logic             cin,
  input  logic [3:0]       shamt,
  input  logic             flip_1,
  input  logic             flip_2,
  input  logic             shift,
  input  logic             SLBI,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic [TAG_W-1:0] tag_out
);

  typedef struct packed {
    logic [15:0]      result;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic logic [15:0] bitrev(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Datapath (combinational, evaluated in the accept cycle)
  // -------------------------------------------------------------------------
  logic [15:0] a_cond, b_cond;
  logic [16:0] sum17;
  logic [15:0] logic_res;
  logic [15:0] s_in, sh_raw, s_out, shift_res;
  logic        is_add;
  entry_t      new_entry;

  assign a_cond = inv_a ? ~a : a;
  assign b_cond = inv_b ? ~b : b;
  assign sum17  = {1'b0, a_cond} + {1'b0, b_cond} + {16'd0, cin};
  assign is_add = !shift && (alu_op == 3'b100);

  // The shifter works on the raw operand a, not the conditioned a_cond.
  assign s_in = flip_1 ? bitrev(a) : a;

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    sh_raw = 16'h0000;
    case (alu_op)
      // A right shift by 16 yields 0, which makes shamt=0 a clean pass-through.
      3'b000:  sh_raw = (s_in << shamt) | (s_in >> (5'd16 - {1'b0, shamt}));
      3'b001:  sh_raw = s_in << shamt;
      3'b010:  sh_raw = 16'($signed(s_in) >>> shamt);
      3'b011:  sh_raw = s_in >> shamt;
      default: sh_raw = 16'h0000;
    endcase
  end

  assign s_out     = flip_2 ? bitrev(sh_raw) : sh_raw;
  assign shift_res = SLBI ? (s_out | {8'h00, b[7:0]}) : s_out;

  always_comb begin
    logic_res = 16'h0000;
    case (alu_op)
      3'b100:  logic_res = sum17[15:0];
      3'b101:  logic_res = a_cond | b_cond;
      3'b110:  logic_res = a_cond ^ b_cond;
      3'b111:  logic_res = a_cond & b_cond;
      default: logic_res = 16'h0000;
    endcase
  end

  always_comb begin
    new_entry.result = shift ? shift_res : logic_res;
    new_entry.z      = (new_entry.result == 16'h0000);
    new_entry.n      = new_entry.result[15];
    new_entry.c      = is_add & sum17[16];
    new_entry.v      = is_add & (a_cond[15] == b_cond[15]) & (sum17[15] != a_cond[15]);
    new_entry.tag    = tag_in;
  end

  // -------------------------------------------------------------------------
  // Main + skid buffer
  // -------------------------------------------------------------------------
  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept, xfer;

  // in_ready depends only on a flop, so there is no combinational path from
  // out_ready back to the producer.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign xfer     = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      // Flush wins over everything, including an accept in the same cycle.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so no accept can coincide with a skid drain.
      if (xfer) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || xfer) begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end
    end else if (xfer) begin
      main_valid_d = 1'b0;
    end
  end

  // NOTE: payload registers are reset as well as the valids, because the
  // outputs must read zero straight out of reset and the entries are tiny.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // the pre-edge value of the others.
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign result    = main_q.result;
  assign flag_z    = main_q.z;
  assign flag_n    = main_q.n;
  assign flag_c    = main_q.c;
  assign flag_v    = main_q.v;
  assign tag_out   = main_q.tag;

endmodule

// File: tb/tb_alu_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_exec
//
// Directed bench for alu_exec. Expected bundles are pushed onto a scoreboard
// queue when the stimulus is accepted, and a monitor pops and compares them
// whenever the DUT completes an output transfer. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_exec;

  localparam int TAG_W = 3;

  typedef struct packed {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [2:0]       alu_op;
    logic             inv_a;
    logic             inv_b;
    logic             cin;
    logic [3:0]       shamt;
    logic             flip_1;
    logic             flip_2;
    logic             shift;
    logic             slbi;
    logic [TAG_W-1:0] tag;
  } stim_t;

  typedef struct packed {
    logic [15:0]      res;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      a, b;
  logic [2:0]       alu_op;
  logic             inv_a, inv_b, cin;
  logic [3:0]       shamt;
  logic             flip_1, flip_2, shift, slbi;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      result;
  logic             flag_z, flag_n, flag_c, flag_v;
  logic [TAG_W-1:0] tag_out;

  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  bit   rand_ready = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .inv_a     (inv_a),
    .inv_b     (inv_b),
    .cin       (cin),
    .shamt     (shamt),
    .flip_1    (flip_1),
    .flip_2    (flip_2),
    .shift     (shift),
    .SLBI      (slbi),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .tag_out   (tag_out)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  function automatic exp_t mkexp(input logic [15:0] r, input logic z, input logic n,
                                 input logic c, input logic v, input logic [TAG_W-1:0] t);
    exp_t e;
    e.res = r; e.z = z; e.n = n; e.c = c; e.v = v; e.tag = t;
    return e;
  endfunction

  // Bit-level reference model used for the randomised vectors.
  function automatic exp_t model(input stim_t s);
    logic [15:0] ap, bp, x, y, r;
    logic [16:0] s17;
    logic        c, v;
    int          sh;
    ap = s.inv_a ? ~s.a : s.a;
    bp = s.inv_b ? ~s.b : s.b;
    c = 1'b0; v = 1'b0; r = 16'h0000;
    sh = int'(s.shamt);
    if (!s.shift) begin
      case (s.alu_op)
        3'b100: begin
          s17 = 17'(ap) + 17'(bp) + 17'(s.cin);
          r = s17[15:0];
          c = s17[16];
          v = (ap[15] == bp[15]) && (r[15] != ap[15]);
        end
        3'b101:  r = ap | bp;
        3'b110:  r = ap ^ bp;
        3'b111:  r = ap & bp;
        default: r = 16'h0000;
      endcase
    end else begin
      for (int i = 0; i < 16; i++) x[i] = s.flip_1 ? s.a[15-i] : s.a[i];
      y = 16'h0000;
      for (int i = 0; i < 16; i++) begin
        case (s.alu_op)
          3'b000: y[(i + sh) % 16] = x[i];
          3'b001: y[i] = (i >= sh) ? x[i-sh] : 1'b0;
          3'b010: y[i] = (i + sh <= 15) ? x[i+sh] : x[15];
          3'b011: y[i] = (i + sh <= 15) ? x[i+sh] : 1'b0;
          default: y[i] = 1'b0;
        endcase
      end
      for (int i = 0; i < 16; i++) r[i] = s.flip_2 ? y[15-i] : y[i];
      if (s.slbi) r[7:0] = r[7:0] | s.b[7:0];
    end
    return mkexp(r, r == 16'h0000, r[15], c, v, s.tag);
  endfunction

  task automatic drive(input stim_t s);
    a = s.a; b = s.b; alu_op = s.alu_op; inv_a = s.inv_a; inv_b = s.inv_b;
    cin = s.cin; shamt = s.shamt; flip_1 = s.flip_1; flip_2 = s.flip_2;
    shift = s.shift; slbi = s.slbi; tag_in = s.tag;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input stim_t s, input exp_t e);
    bit done = 1'b0;
    drive(s);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!done) check("send_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_drain();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && sb.size() != 0; cyc++) begin
      @(negedge clk); #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: a transfer completes on the next rising edge whenever out_valid
  // and out_ready are both high at the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      exp_t obs;
      obs = mkexp(result, flag_z, flag_n, flag_c, flag_v, tag_out);
      xfers++;
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(obs), 32'h7FFFFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_bundle", 32'(obs), 32'(e));
      end
    end
  end

  initial begin
    stim_t s;
    logic [15:0] held;
    int xfers_before;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive('0);

    // Reset state, before any clock edge.
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_result",    32'(result),    32'd0);
    check("rst_flags",     32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    check("rst_tag",       32'(tag_out),   32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed datapath vectors, streamed with out_ready high.
    out_ready = 1'b1;
    s = '0; s.a = 16'h7FFF; s.b = 16'h0001; s.alu_op = 3'b100; s.tag = 3'd1;
    send(s, mkexp(16'h8000, 0, 1, 0, 1, 3'd1));
    check("add_latency_valid",  32'(out_valid), 32'd1);
    check("add_latency_result", 32'(result),    32'h8000);

    s = '0; s.a = 16'h0005; s.b = 16'h0005; s.alu_op = 3'b100; s.inv_a = 1; s.cin = 1; s.tag = 3'd2;
    send(s, mkexp(16'h0000, 1, 0, 1, 0, 3'd2));
    s.a = 16'h0006; s.tag = 3'd3;
    send(s, mkexp(16'hFFFF, 0, 1, 0, 0, 3'd3));

    s = '0; s.a = 16'h1234; s.alu_op = 3'b000; s.shamt = 4'd4; s.flip_1 = 1; s.flip_2 = 1;
    s.shift = 1; s.tag = 3'd4;
    send(s, mkexp(16'h4123, 0, 0, 0, 0, 3'd4));

    s = '0; s.a = 16'h8000; s.alu_op = 3'b011; s.shamt = 4'd15; s.shift = 1; s.tag = 3'd5;
    send(s, mkexp(16'h0001, 0, 0, 0, 0, 3'd5));

    s = '0; s.a = 16'hFFFF; s.b = 16'h00FF; s.alu_op = 3'b111; s.inv_b = 1; s.tag = 3'd6;
    send(s, mkexp(16'hFF00, 0, 1, 0, 0, 3'd6));

    s = '0; s.a = 16'h00AB; s.b = 16'h00CD; s.alu_op = 3'b001; s.shamt = 4'd8; s.shift = 1;
    s.slbi = 1; s.tag = 3'd7;
    send(s, mkexp(16'hABCD, 0, 1, 0, 0, 3'd7));

    // shift=0 with alu_op 0xx yields zero.
    s = '0; s.a = 16'h1234; s.b = 16'h4321; s.alu_op = 3'b010; s.tag = 3'd0;
    send(s, mkexp(16'h0000, 1, 0, 0, 0, 3'd0));
    wait_drain();

    // Randomised vectors against the model with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      s = stim_t'({$urandom, $urandom});
      s.tag = 3'(i);
      send(s, model(s));
    end
    rand_ready = 1'b0;
    wait_drain();

    // Backpressure: tags 1,2 fill main and skid, tag 3 waits on the input.
    out_ready = 1'b0;
    xfers_before = xfers;
    s = '0; s.alu_op = 3'b100; s.a = 16'h0100; s.b = 16'h0001; s.tag = 3'd1;
    send(s, model(s));
    s.a = 16'h0200; s.tag = 3'd2;
    send(s, model(s));
    s.a = 16'h0300; s.tag = 3'd3;
    drive(s);
    in_valid = 1'b1;
    sb.push_back(model(s));
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_tag_main",     32'(tag_out),  32'd1);
    held = result;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_stable_result", 32'(result),   32'(held));
    check("bp_stable_valid",  32'(out_valid), 32'd1);
    check("bp_still_low",     32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_low_until_drain", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    check("bp_tag2_main",     32'(tag_out),  32'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_tag3_main", 32'(tag_out), 32'd3);
    @(posedge clk); #1;
    wait_drain();
    check("bp_xfer_count", 32'(xfers - xfers_before), 32'd3);

    // Flush with both entries full and a bundle on the input.
    out_ready = 1'b0;
    s = '0; s.alu_op = 3'b101; s.a = 16'h00F0; s.b = 16'h000F; s.tag = 3'd4;
    send(s, model(s));
    s.tag = 3'd5;
    send(s, model(s));
    s.tag = 3'd6;
    drive(s);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready",  32'(in_ready),  32'd1);

    // Flush coinciding with an accept into an empty buffer discards it.
    @(posedge clk); #1;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_accept_dropped", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Stream resumes cleanly after flush.
    s = '0; s.alu_op = 3'b110; s.a = 16'hA5A5; s.b = 16'hFFFF; s.tag = 3'd7;
    send(s, model(s));
    wait_drain();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    s = '0; s.alu_op = 3'b100; s.a = 16'h1111; s.b = 16'h2222; s.tag = 3'd2;
    send(s, model(s));
    s.tag = 3'd3;
    send(s, model(s));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_result",    32'(result),    32'd0);
    check("arst_flags",     32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    check("arst_tag",       32'(tag_out),   32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    s = '0; s.alu_op = 3'b100; s.a = 16'h8000; s.b = 16'h8000; s.tag = 3'd5;
    send(s, mkexp(16'h0000, 1, 0, 1, 1, 3'd5));
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
